// File: rtl/intc_pkg.sv
// Shared definitions for the external-interrupt controller.
//   - intc_state_e   : controller FSM states
//   - EXC_INT        : exception code reported for external interrupts
//   - STATUS_IE_BIT  : CP0 Status global interrupt enable bit
//   - STATUS_IM_BASE : CP0 Status bit of the mask-enable for line 0
package intc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } intc_state_e;

  localparam logic [4:0]  EXC_INT        = 5'd0;
  localparam int unsigned STATUS_IE_BIT  = 0;
  localparam int unsigned STATUS_IM_BASE = 8;

endpackage

// File: rtl/irq_sync.sv
// Single-line interrupt synchronizer.
// Two flops bring the asynchronous peripheral line into the clk domain. With EdgeEn set, a third
// flop turns the synchronized level into a one-cycle rising-edge pulse.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   irq   : raw peripheral line
//   sig   : synchronized level (EdgeEn = 0) or rising-edge pulse (EdgeEn = 1)
module irq_sync #(
  parameter bit EdgeEn = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic sig
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= irq;
      s2_q <= s1_q;
    end
  end

  if (EdgeEn) begin : g_edge
    logic s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s3_q <= 1'b0;
      end else begin
        s3_q <= s2_q;
      end
    end

    assign sig = s2_q & ~s3_q;
  end else begin : g_level
    assign sig = s2_q;
  end

endmodule

// File: rtl/intr_ctrl.sv
// External-interrupt controller for the multicycle MIPS core.
// Collects N_IRQ peripheral lines into a pending register, qualifies them with CP0 Status IE and
// per-line mask bits, and raises a held request (lowest index wins) at an instruction boundary.
// The request is held until the controller acknowledges it, or withdrawn if the latched line
// stops being eligible; after acknowledge the block waits in SERVICE until eret.
// Build option: define INTC_EDGE_DETECT_EN for edge-triggered lines (pending set by rising edge,
// cleared by acknowledge). Default build is level mode (pending is the synchronized line).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   irq_in         : raw peripheral interrupt lines
//   status         : CP0 Status (bit 0 IE, bit 8+i mask for line i)
//   instr_boundary : controller can accept an interrupt this cycle
//   intr_ack       : controller takes the pending request
//   eret           : eret executing, ends the service window
//   intr_req       : interrupt request to controller
//   cause          : exception code (always Int)
//   irq_id         : index of the line requested or serviced
//   pending        : raw pending bits for Cause.IP
module intr_ctrl
  import intc_pkg::*;
#(
  parameter int unsigned N_IRQ = 6,
  parameter int unsigned ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [31:0]      status,
  input  logic             instr_boundary,
  input  logic             intr_ack,
  input  logic             eret,
  output logic             intr_req,
  output logic [4:0]       cause,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_IRQ-1:0] pending
);

`ifdef INTC_EDGE_DETECT_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  intc_state_e     state_q, state_d;
  logic [ID_W-1:0] irq_id_q, irq_id_d;
  logic [N_IRQ-1:0] line_sig;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] elig;
  logic [ID_W-1:0]  win_id;
  logic             win_vld;
  logic             take;

  // Status bits outside IE and the used mask range are deliberately ignored.
  logic unused_status;
  assign unused_status = ^{status[31:STATUS_IM_BASE+N_IRQ],
                           status[STATUS_IM_BASE-1:STATUS_IE_BIT+1]};

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_sync #(
      .EdgeEn(EdgeEn)
    ) u_irq_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .irq  (irq_in[i]),
      .sig  (line_sig[i])
    );
  end

`ifdef INTC_EDGE_DETECT_EN
  logic [N_IRQ-1:0] pend_q, pend_d, clr;

  // A rising edge landing on the same cycle as the clear keeps the bit set.
  always_comb begin
    clr    = take ? (N_IRQ'(1) << irq_id_q) : '0;
    pend_d = (pend_q & ~clr) | line_sig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  assign pend = line_sig;
`endif

  assign elig = pend & status[STATUS_IM_BASE +: N_IRQ] & {N_IRQ{status[STATUS_IE_BIT]}};

  // Fixed priority: scan downward so the lowest eligible index is the last written.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_id  = ID_W'(i);
        win_vld = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
    end
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld && instr_boundary) begin
          state_d  = StReq;
          irq_id_d = win_id;
        end
      end
      StReq: begin
        // Acknowledge beats withdrawal in the same cycle.
        if (intr_ack) begin
          state_d = StService;
        end else if (!elig[irq_id_q]) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (eret) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    intr_req = (state_q == StReq);
    take     = (state_q == StReq) && intr_ack;
  end

  assign irq_id  = irq_id_q;
  assign cause   = EXC_INT;
  assign pending = pend;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  localparam int N_IRQ = 6;
  localparam int ID_W  = 3;
  localparam logic [31:0] S2  = 32'h0000_0401;
  localparam logic [31:0] S14 = 32'h0000_1201;
  localparam logic [31:0] SM  = 32'h0000_1200;

  logic             clk;
  logic             rst_n;
  logic [N_IRQ-1:0] irq_in;
  logic [31:0]      status;
  logic             instr_boundary;
  logic             intr_ack;
  logic             eret;
  logic             intr_req;
  logic [4:0]       cause;
  logic [ID_W-1:0]  irq_id;
  logic [N_IRQ-1:0] pending;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [5:0]  irq;
    logic [31:0] st;
    logic        ib;
    logic        ack;
    logic        er;
    logic        req;
    logic [2:0]  id;
    logic [5:0]  pend;
  } vec_t;

  vec_t tbl[$];

  intr_ctrl #(
    .N_IRQ(N_IRQ),
    .ID_W (ID_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_in        (irq_in),
    .status        (status),
    .instr_boundary(instr_boundary),
    .intr_ack      (intr_ack),
    .eret          (eret),
    .intr_req      (intr_req),
    .cause         (cause),
    .irq_id        (irq_id),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [5:0] irq, logic [31:0] st, logic ib, logic ack, logic er,
                              logic req, logic [2:0] id, logic [5:0] pend);
    vec_t v;
    v.irq = irq; v.st = st; v.ib = ib; v.ack = ack; v.er = er;
    v.req = req; v.id = id; v.pend = pend;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the rising edge that consumes them.
  task automatic step(input logic [5:0] irq, input logic [31:0] st, input logic ib,
                      input logic ack, input logic er);
    @(negedge clk);
    irq_in = irq; status = st; instr_boundary = ib; intr_ack = ack; eret = er;
    @(posedge clk);
    #1;
  endtask

  initial begin
    irq_in = 6'h3F; status = '0; instr_boundary = 1'b0; intr_ack = 1'b0; eret = 1'b0;
    rst_n = 1'b0;

`ifdef INTC_EDGE_DETECT_EN
    tbl.push_back(mk(6'h00, 32'h0, 1, 0, 0, 0, 0, 6'h00));
    tbl.push_back(mk(6'h04, S2,    1, 0, 0, 0, 0, 6'h00));
    tbl.push_back(mk(6'h04, S2,    1, 0, 0, 0, 0, 6'h00));
    tbl.push_back(mk(6'h04, S2,    0, 0, 0, 0, 0, 6'h04));
    tbl.push_back(mk(6'h04, S2,    1, 0, 0, 1, 2, 6'h04));
    tbl.push_back(mk(6'h04, S2,    1, 1, 0, 0, 2, 6'h00));
    tbl.push_back(mk(6'h04, S2,    1, 0, 1, 0, 2, 6'h00));
    tbl.push_back(mk(6'h04, S2,    1, 0, 0, 0, 2, 6'h00));
    tbl.push_back(mk(6'h00, S2,    1, 0, 0, 0, 2, 6'h00));
    tbl.push_back(mk(6'h12, S14,   1, 0, 0, 0, 2, 6'h00));
    tbl.push_back(mk(6'h12, S14,   1, 0, 0, 0, 2, 6'h00));
    tbl.push_back(mk(6'h12, S14,   1, 0, 0, 0, 2, 6'h12));
    tbl.push_back(mk(6'h12, S14,   1, 0, 0, 1, 1, 6'h12));
    tbl.push_back(mk(6'h12, S14,   1, 1, 0, 0, 1, 6'h10));
    tbl.push_back(mk(6'h12, S14,   1, 0, 1, 0, 1, 6'h10));
    tbl.push_back(mk(6'h12, S14,   1, 0, 0, 1, 4, 6'h10));
    tbl.push_back(mk(6'h12, SM,    1, 0, 0, 0, 4, 6'h10));
    tbl.push_back(mk(6'h12, S14,   1, 0, 0, 1, 4, 6'h10));
    tbl.push_back(mk(6'h12, S14,   1, 1, 0, 0, 4, 6'h00));
    tbl.push_back(mk(6'h12, S14,   1, 0, 1, 0, 4, 6'h00));
    tbl.push_back(mk(6'h00, S14,   1, 0, 0, 0, 4, 6'h00));
`else
    tbl.push_back(mk(6'h00, 32'h0, 1, 0, 0, 0, 0, 6'h00));
    tbl.push_back(mk(6'h04, S2,    1, 0, 0, 0, 0, 6'h00));
    tbl.push_back(mk(6'h04, S2,    1, 0, 0, 0, 0, 6'h04));
    tbl.push_back(mk(6'h04, S2,    0, 0, 0, 0, 0, 6'h04));
    tbl.push_back(mk(6'h00, S2,    1, 0, 0, 1, 2, 6'h04));
    tbl.push_back(mk(6'h00, S2,    1, 0, 0, 1, 2, 6'h00));
    tbl.push_back(mk(6'h00, S2,    1, 1, 0, 0, 2, 6'h00));
    tbl.push_back(mk(6'h00, S2,    1, 0, 0, 0, 2, 6'h00));
    tbl.push_back(mk(6'h00, S2,    1, 0, 1, 0, 2, 6'h00));
    tbl.push_back(mk(6'h00, S2,    1, 1, 0, 0, 2, 6'h00));
    tbl.push_back(mk(6'h12, S14,   1, 0, 0, 0, 2, 6'h00));
    tbl.push_back(mk(6'h12, S14,   1, 0, 0, 0, 2, 6'h12));
    tbl.push_back(mk(6'h12, S14,   1, 0, 0, 1, 1, 6'h12));
    tbl.push_back(mk(6'h12, S14,   1, 0, 1, 1, 1, 6'h12));
    tbl.push_back(mk(6'h12, S14,   1, 1, 0, 0, 1, 6'h12));
    tbl.push_back(mk(6'h10, S14,   1, 0, 0, 0, 1, 6'h12));
    tbl.push_back(mk(6'h10, S14,   1, 0, 1, 0, 1, 6'h10));
    tbl.push_back(mk(6'h10, S14,   1, 0, 0, 1, 4, 6'h10));
    tbl.push_back(mk(6'h10, SM,    1, 0, 0, 0, 4, 6'h10));
    tbl.push_back(mk(6'h10, SM,    1, 0, 0, 0, 4, 6'h10));
    tbl.push_back(mk(6'h10, S14,   1, 0, 0, 1, 4, 6'h10));
    tbl.push_back(mk(6'h00, S14,   1, 1, 0, 0, 4, 6'h10));
    tbl.push_back(mk(6'h00, S14,   1, 0, 0, 0, 4, 6'h00));
    tbl.push_back(mk(6'h00, S14,   1, 0, 1, 0, 4, 6'h00));
    tbl.push_back(mk(6'h00, S14,   1, 0, 0, 0, 4, 6'h00));
    tbl.push_back(mk(6'h08, S14,   1, 0, 0, 0, 4, 6'h00));
    tbl.push_back(mk(6'h08, S14,   1, 0, 0, 0, 4, 6'h08));
    tbl.push_back(mk(6'h08, S14,   1, 0, 0, 0, 4, 6'h08));
    tbl.push_back(mk(6'h00, S14,   1, 0, 0, 0, 4, 6'h08));
    tbl.push_back(mk(6'h00, S14,   1, 0, 0, 0, 4, 6'h00));
`endif

    // Reset with all lines high: everything must stay at zero.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 0, 32'(intr_req), 32'h0);
    chk("rst_id", 0, 32'(irq_id), 32'h0);
    chk("rst_pend", 0, 32'(pending), 32'h0);
    chk("rst_cause", 0, 32'(cause), 32'h0);
    @(negedge clk);
    irq_in = '0;
    rst_n  = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].irq, tbl[i].st, tbl[i].ib, tbl[i].ack, tbl[i].er);
      chk("req", i, 32'(intr_req), 32'(tbl[i].req));
      chk("id", i, 32'(irq_id), 32'(tbl[i].id));
      chk("pend", i, 32'(pending), 32'(tbl[i].pend));
      chk("cause", i, 32'(cause), 32'h0);
    end

    // Acknowledge of line 0 coinciding with new activity on line 0 keeps it pending.
`ifdef INTC_EDGE_DETECT_EN
    step(6'h01, 32'h101, 1, 0, 0);
    step(6'h00, 32'h101, 1, 0, 0);
    step(6'h01, 32'h101, 1, 0, 0);
    step(6'h00, 32'h101, 1, 0, 0);
    chk("sim_req", 0, 32'(intr_req), 32'h1);
    chk("sim_id", 0, 32'(irq_id), 32'h0);
    step(6'h00, 32'h101, 1, 1, 0);
    chk("sim_pend0", 0, 32'(pending[0]), 32'h1);
    chk("sim_req", 1, 32'(intr_req), 32'h0);
    step(6'h00, 32'h101, 1, 0, 1);
    chk("sim_req", 2, 32'(intr_req), 32'h0);
    step(6'h00, 32'h101, 1, 0, 0);
`else
    step(6'h01, 32'h101, 1, 0, 0);
    step(6'h01, 32'h101, 1, 0, 0);
    step(6'h01, 32'h101, 1, 0, 0);
    chk("sim_req", 0, 32'(intr_req), 32'h1);
    chk("sim_id", 0, 32'(irq_id), 32'h0);
    step(6'h01, 32'h101, 1, 1, 0);
    chk("sim_pend0", 0, 32'(pending[0]), 32'h1);
    chk("sim_req", 1, 32'(intr_req), 32'h0);
    step(6'h01, 32'h101, 1, 0, 1);
    chk("sim_req", 2, 32'(intr_req), 32'h0);
    step(6'h01, 32'h101, 1, 0, 0);
`endif
    chk("sim_rereq", 0, 32'(intr_req), 32'h1);
    chk("sim_reid", 0, 32'(irq_id), 32'h0);

    // Asynchronous reset while requesting: no clock edge between assert and check.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 0, 32'(intr_req), 32'h0);
    chk("arst_id", 0, 32'(irq_id), 32'h0);
    chk("arst_pend", 0, 32'(pending), 32'h0);
    irq_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(6'h00, 32'h101, 1, 0, 0);
    chk("post_req", 0, 32'(intr_req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
